// File: rtl/tile_flip_pkg.sv
// Shared types and constants for the tile-flip game video path:
// tile state codes, 12-bit colours, 640x480@60 timing defaults.
package tile_flip_pkg;

    typedef enum logic [1:0] {
        TILE_HIDDEN     = 2'b00,
        TILE_SELECTED   = 2'b01,
        TILE_MATCHED    = 2'b10,
        TILE_MISMATCHED = 2'b11
    } tile_code_t;

    localparam logic [11:0] COL_BLACK  = 12'h000;
    localparam logic [11:0] COL_BLUE   = 12'h00F;
    localparam logic [11:0] COL_WHITE  = 12'hFFF;
    localparam logic [11:0] COL_GREEN  = 12'h0F0;
    localparam logic [11:0] COL_RED    = 12'hF00;
    localparam logic [11:0] COL_CURSOR = 12'hFF0;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic logic [11:0] tile_colour(input logic [1:0] code);
        logic [11:0] c;
        c = COL_BLACK;
        unique case (code)
            TILE_HIDDEN:     c = COL_BLUE;
            TILE_SELECTED:   c = COL_WHITE;
            TILE_MATCHED:    c = COL_GREEN;
            TILE_MISMATCHED: c = COL_RED;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA h/v counters, raw (unpipelined) active-low syncs and active flag.
// Ports: clk, reset, pix_en in; h_cnt, v_cnt, line_end, frame_end,
//        hsync_raw, vsync_raw, active_raw out.
module vga_timing_gen
    import tile_flip_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          line_end,
    output logic          frame_end,
    output logic          hsync_raw,
    output logic          vsync_raw,
    output logic          active_raw
);

    localparam int HS_BEG = H_DISPLAY + H_FRONT;
    localparam int VS_BEG = V_DISPLAY + V_FRONT;

    assign line_end  = int'(h_cnt) == H_TOTAL - 1;
    // Last pixel of the last active line: the frame snapshot point.
    assign frame_end = line_end && int'(v_cnt) == V_DISPLAY - 1;

    assign hsync_raw = !(int'(h_cnt) >= HS_BEG &&
                         int'(h_cnt) < HS_BEG + H_SYNC);
    assign vsync_raw = !(int'(v_cnt) >= VS_BEG &&
                         int'(v_cnt) < VS_BEG + V_SYNC);
    assign active_raw = int'(h_cnt) < H_DISPLAY &&
                        int'(v_cnt) < V_DISPLAY;

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                h_cnt <= '0;
                if (int'(v_cnt) == V_TOTAL - 1) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_tile_renderer.sv
// VGA tile-grid renderer: per-frame tile snapshot, incremental tile
// counters and a 2-stage colour pipeline aligned with the syncs.
// Ports: clk, reset, pix_en, tile_state, cursor_idx in;
//        hsync, vsync, rgb, frame_start, active out.
// Optional cursor outline: define VGA_TILE_CURSOR_EN.
module vga_tile_renderer
    import tile_flip_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int GRID_COLS = 4,
    parameter int GRID_ROWS = 4,
    parameter int TILE_SIZE = 80,
    parameter int TILE_GAP  = 4,
    parameter int GRID_X    = 120,
    parameter int GRID_Y    = 60,
    localparam int N_TILES  = GRID_COLS * GRID_ROWS,
    localparam int IW       = $clog2(N_TILES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic [2*N_TILES-1:0] tile_state,
    input  logic [IW-1:0]      cursor_idx,
    output logic               hsync,
    output logic               vsync,
    output logic [11:0]        rgb,
    output logic               frame_start,
    output logic               active
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int OW      = $clog2(TILE_SIZE);
    localparam int CW      = $clog2(GRID_COLS + 1);
    localparam int RW      = $clog2(GRID_ROWS + 1);
    localparam int FILL    = TILE_SIZE - TILE_GAP;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          line_end;
    logic          frame_end;
    logic          hsync_raw;
    logic          vsync_raw;
    logic          active_raw;

    vga_timing_gen #(
        .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT),
        .H_SYNC(H_SYNC),       .H_BACK(H_BACK),
        .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT),
        .V_SYNC(V_SYNC),       .V_BACK(V_BACK)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .line_end  (line_end),
        .frame_end (frame_end),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .active_raw(active_raw)
    );

    // ---------------- frame snapshot ----------------
    logic [2*N_TILES-1:0] snap;

    assign frame_start = pix_en && frame_end && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            snap <= '0;
        end else if (frame_start) begin
            snap <= tile_state;
        end
    end

`ifdef VGA_TILE_CURSOR_EN
    logic [IW-1:0] cur_snap;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_snap <= '0;
        end else if (frame_start) begin
            cur_snap <= cursor_idx;
        end
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^cursor_idx;
`endif

    // ---------------- tile position counters ----------------
    // Counters describe the current h_cnt/v_cnt, so they are loaded
    // one step early from the next counter value.
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic [OW-1:0] x_off;
    logic [OW-1:0] y_off;
    logic [CW-1:0] col_idx;
    logic [RW-1:0] row_idx;

    assign h_nxt = line_end ? '0 : h_cnt + 1'b1;
    assign v_nxt = (int'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_off   <= '0;
            col_idx <= '0;
            y_off   <= '0;
            row_idx <= '0;
        end else if (pix_en) begin
            if (int'(h_nxt) == GRID_X) begin
                x_off   <= '0;
                col_idx <= '0;
            end else if (int'(x_off) == TILE_SIZE - 1) begin
                x_off   <= '0;
                col_idx <= col_idx + 1'b1;
            end else begin
                x_off <= x_off + 1'b1;
            end
            if (line_end) begin
                if (int'(v_nxt) == GRID_Y) begin
                    y_off   <= '0;
                    row_idx <= '0;
                end else if (int'(y_off) == TILE_SIZE - 1) begin
                    y_off   <= '0;
                    row_idx <= row_idx + 1'b1;
                end else begin
                    y_off <= y_off + 1'b1;
                end
            end
        end
    end

    // ---------------- stage 1 ----------------
    logic          in_grid_c;
    logic          gap_c;
    logic [IW-1:0] tile_c;

    assign in_grid_c =
        int'(h_cnt) >= GRID_X &&
        int'(h_cnt) <  GRID_X + GRID_COLS * TILE_SIZE &&
        int'(v_cnt) >= GRID_Y &&
        int'(v_cnt) <  GRID_Y + GRID_ROWS * TILE_SIZE;
    assign gap_c = int'(x_off) >= FILL || int'(y_off) >= FILL;
    // Column/row counters run past the grid; only index when inside.
    assign tile_c = in_grid_c ?
        IW'(int'(row_idx) * GRID_COLS + int'(col_idx)) : '0;

    logic          s1_in_grid;
    logic          s1_gap;
    logic          s1_active;
    logic          s1_hsync;
    logic          s1_vsync;
    logic [IW-1:0] s1_tile;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_in_grid <= 1'b0;
            s1_gap     <= 1'b0;
            s1_active  <= 1'b0;
            s1_hsync   <= 1'b1;
            s1_vsync   <= 1'b1;
            s1_tile    <= '0;
        end else if (pix_en) begin
            s1_in_grid <= in_grid_c;
            s1_gap     <= gap_c;
            s1_active  <= active_raw;
            s1_hsync   <= hsync_raw;
            s1_vsync   <= vsync_raw;
            s1_tile    <= tile_c;
        end
    end

`ifdef VGA_TILE_CURSOR_EN
    logic border_c;
    logic s1_border;

    assign border_c = int'(x_off) < 3 || int'(y_off) < 3 ||
                      int'(x_off) >= FILL - 3 ||
                      int'(y_off) >= FILL - 3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_border <= 1'b0;
        end else if (pix_en) begin
            s1_border <= border_c;
        end
    end
`endif

    // ---------------- stage 2 ----------------
    logic [1:0]  s1_code;
    logic [11:0] pix_c;

    assign s1_code = snap[{s1_tile, 1'b0} +: 2];

    always_comb begin
        pix_c = COL_BLACK;
        if (s1_active && s1_in_grid && !s1_gap) begin
            pix_c = tile_colour(s1_code);
`ifdef VGA_TILE_CURSOR_EN
            if (s1_border && s1_tile == cur_snap) begin
                pix_c = COL_CURSOR;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            active <= 1'b0;
            rgb    <= COL_BLACK;
        end else if (pix_en) begin
            hsync  <= s1_hsync;
            vsync  <= s1_vsync;
            active <= s1_active;
            rgb    <= pix_c;
        end
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer on a shrunken 80x64 raster
// (64x56 active, 4x4 grid of 12-px tiles with 2-px gaps at (6,4)).
module tb_vga_tile_renderer;

    localparam int HT = 80;
    localparam int VT = 64;
    localparam int FT = HT * VT;

`ifdef VGA_TILE_CURSOR_EN
    localparam logic [11:0] CUR_BLUE  = 12'hFF0;
    localparam logic [11:0] CUR_GREEN = 12'hFF0;
`else
    localparam logic [11:0] CUR_BLUE  = 12'h00F;
    localparam logic [11:0] CUR_GREEN = 12'h0F0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [31:0] tile_state;
    logic [3:0]  cursor_idx;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        frame_start;
    logic        active;

    int n_vec = 0;
    int n_bad = 0;
    int pos   = 0;
    bit stretch = 1'b0;

    vga_tile_renderer #(
        .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(56), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
        .GRID_COLS(4),  .GRID_ROWS(4),
        .TILE_SIZE(12), .TILE_GAP(2),
        .GRID_X(6),     .GRID_Y(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .tile_state (tile_state),
        .cursor_idx (cursor_idx),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .frame_start(frame_start),
        .active     (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One pixel step; in stretch mode three idle clocks follow it.
    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            pix_en = 1'b1;
            @(posedge clk);
            #1;
            pos++;
            if (stretch) begin
                pix_en = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    // Advance until the counter value (x,y) is lat steps in the past.
    task automatic goto(input int x, input int y, input int lat);
        int t;
        t = (pos / FT) * FT + y * HT + x + lat;
        if (t < pos) t += FT;
        adv(t - pos);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rgb", 32'(rgb), 32'h000);
        chk("rst_sync", {30'd0, hsync, vsync}, 32'h3);
        chk("rst_act", 32'(active), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);
        reset = 1'b0;
        pos = 0;
    endtask

    initial begin
        reset      = 1'b1;
        pix_en     = 1'b1;
        tile_state = '0;
        cursor_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // frame 0: snapshot all hidden, cursor 0
        goto(5, 4, 2);
        chk("left_of_grid", 32'(rgb), 32'h000);
        chk("left_act", 32'(active), 32'h1);
        goto(6, 4, 2);
        chk("grid_first_px", 32'(rgb), 32'(CUR_BLUE));
        goto(15, 4, 2);
        chk("last_fill_px", 32'(rgb), 32'(CUR_BLUE));
        goto(16, 4, 2);
        chk("first_gap_px", 32'(rgb), 32'h000);
        goto(51, 4, 2);
        chk("col3_fill", 32'(rgb), 32'h00F);
        goto(52, 4, 2);
        chk("col3_gap", 32'(rgb), 32'h000);
        goto(11, 9, 2);
        chk("t0_interior", 32'(rgb), 32'h00F);
        goto(63, 10, 2);
        chk("act_last", 32'(active), 32'h1);
        goto(64, 10, 2);
        chk("act_off", 32'(active), 32'h0);
        goto(67, 10, 2);
        chk("hs_before", 32'(hsync), 32'h1);
        goto(68, 10, 2);
        chk("hs_first", 32'(hsync), 32'h0);
        goto(75, 10, 2);
        chk("hs_last", 32'(hsync), 32'h0);
        goto(76, 10, 2);
        chk("hs_after", 32'(hsync), 32'h1);
        goto(11, 14, 2);
        chk("row_gap", 32'(rgb), 32'h000);

        // mid-frame input change: tile1=01, tile5=10, tile6=11, cursor 5
        tile_state[3:2]   = 2'b01;
        tile_state[11:10] = 2'b10;
        tile_state[13:12] = 2'b11;
        cursor_idx        = 4'd5;
        goto(23, 21, 2);
        chk("no_tear", 32'(rgb), 32'h00F);
        goto(78, 55, 0);
        chk("fs_early", 32'(frame_start), 32'h0);
        goto(79, 55, 0);
        chk("fs_pulse", 32'(frame_start), 32'h1);
        goto(0, 57, 2);
        chk("vs_before", 32'(vsync), 32'h1);
        goto(0, 58, 2);
        chk("vs_first", 32'(vsync), 32'h0);
        goto(79, 59, 2);
        chk("vs_last", 32'(vsync), 32'h0);
        goto(0, 60, 2);
        chk("vs_after", 32'(vsync), 32'h1);

        // frame 1: new snapshot
        goto(23, 9, 2);
        chk("t1_white", 32'(rgb), 32'hFFF);
        goto(18, 16, 2);
        chk("t5_corner", 32'(rgb), 32'(CUR_GREEN));
        goto(23, 21, 2);
        chk("t5_green", 32'(rgb), 32'h0F0);
        goto(35, 21, 2);
        chk("t6_red", 32'(rgb), 32'hF00);

        // pix_en one cycle in four
        stretch = 1'b1;
        goto(15, 33, 2);
        chk("slow_px", 32'(rgb), 32'h00F);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("hold", {17'd0, hsync, vsync, active, rgb}, 32'h700F);
        goto(68, 40, 2);
        chk("slow_hs", 32'(hsync), 32'h0);
        goto(79, 55, 0);
        chk("fs_idle", 32'(frame_start), 32'h0);
        pix_en = 1'b1;
        #1;
        chk("fs_slow", 32'(frame_start), 32'h1);
        stretch = 1'b0;

        // frame 2: reset mid-frame
        goto(23, 33, 2);
        chk("pre_rst_rgb", 32'(rgb), 32'h00F);
        do_reset();
        goto(6, 4, 2);
        chk("post_rst_t0", 32'(rgb), 32'(CUR_BLUE));
        goto(23, 9, 2);
        chk("post_rst_t1", 32'(rgb), 32'h00F);
        goto(23, 21, 2);
        chk("post_rst_t5", 32'(rgb), 32'h00F);
        goto(78, 55, 0);
        chk("post_rst_fs0", 32'(frame_start), 32'h0);
        goto(79, 55, 0);
        chk("post_rst_fs1", 32'(frame_start), 32'h1);
        goto(23, 21, 2);
        chk("resnap_t5", 32'(rgb), 32'h0F0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
